off_chip_spi_flash_responder: RTL and testbench
===============================================

OFF_CHIP_SPI_FLASH_RESPONDER -- requirements
Module: off_chip_spi_flash_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 64, number of 32-bit memory words.
REQ-002 SHALL have parameter AW, default 6, word-index width (log2 DEPTH).
REQ-003 SHALL have parameter READ_OP, default 8'h03, read opcode.
REQ-004 SHALL have parameter WRITE_OP, default 8'h02, write opcode.
REQ-005 SHALL have port clk, input, 1 bit: single system clock; all bit transfers occur on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port CSbar, input, 1 bit: chip select, active low; a low level frames a transaction.
REQ-008 SHALL have port DI, input, 1 bit: serial data from the initiator, sampled MSB first.
REQ-009 SHALL have port DO, output, 1 bit: serial data to the initiator, registered.
REQ-010 SHALL have port busy, output, 1 bit: high while state is not IDLE.
REQ-011 SHALL have port writeDone, output, 1 bit: one-cycle pulse when a write commits.

Function
REQ-012 SHALL number the cycles of a transaction k = 0, 1, ...; k = 0 is the first rising edge with CSbar low after IDLE.
REQ-013 SHALL use states IDLE, CMD (k 0..7), ADDR (k 8..31), READ, WRITE and DONE (k 32..63 for READ/WRITE).
REQ-014 SHALL sample DI at k = 0..7 into an 8-bit opcode, MSB first.
REQ-015 SHALL sample DI at k = 8..31 into a 24-bit address, MSB first.
REQ-016 SHALL use address[AW-1:0] as the word index; upper address bits are ignored, so indexes wrap modulo DEPTH.
REQ-017 SHALL go from ADDR to READ after k = 31 if opcode == READ_OP.
REQ-018 SHALL go from ADDR to WRITE after k = 31 if opcode == WRITE_OP.
REQ-019 SHALL go from ADDR to DONE after k = 31 for any other opcode; no memory access occurs and DO stays 0.
REQ-020 SHALL, on the k = 31 edge of a READ_OP transaction, load mem[index] into a 32-bit output shift register; the index is formed from the 23 sampled address bits plus DI at k = 31.
REQ-021 SHALL drive DO = word[63-k] during k = 32..63 of a read, i.e. bit 31 is valid in the cycle after the last address bit.
REQ-022 SHALL, in WRITE, shift DI in during k = 32..63 and, on the k = 63 edge, write the 32-bit word to mem[index].
REQ-023 SHALL pulse writeDone high for exactly the cycle after the k = 63 edge of a write.
REQ-024 SHALL go from READ or WRITE to DONE after k = 63.
REQ-025 SHALL, in DONE, ignore DI and hold DO = 0 until CSbar rises.
REQ-026 SHALL return to IDLE on the edge after CSbar is sampled high, from any state.
REQ-027 SHALL NOT write memory if CSbar rises before the k = 63 edge; the aborted write is discarded.
REQ-028 SHALL drive DO = 0 in all states except READ.
REQ-029 SHALL use a 6-bit bit counter that clears in IDLE and saturates at 63 in DONE.
REQ-030 SHALL allow back-to-back transactions: CSbar high for one cycle then low starts a new transaction at k = 0.

Reset
REQ-031 SHALL, on rst high at a rising clk edge, set state IDLE, counter 0, DO 0, busy 0 and writeDone 0, overriding CSbar.
REQ-032 SHALL, when rst is asserted mid-transaction, abort that transaction with no memory write.
REQ-033 SHALL NOT initialise memory contents on reset.

Structure
REQ-034 SHALL place the opcode constants, state encodings and DEPTH/AW defaults in a shared off_chip_spi_flash package/include used by both the initiator and the responder.
REQ-035 SHALL implement the 32-bit load/shift register as one sub-module, off_chip_spi_flash_shift_reg (parallel load, shift-left with serial-in, synchronous reset).
REQ-036 SHALL implement the memory as inferred RAM: synchronous write, read captured into the shift register.

Verification
REQ-037 SHALL cover write: opcode 02, address 000005, data 32'hDEADBEEF, CSbar low 64 cycles -> writeDone pulses once after k = 63; mem[5] = DEADBEEF.
REQ-038 SHALL cover read-back: opcode 03, address 000005 -> DO during k = 32..63 serialises DEADBEEF MSB first; DO = 0 otherwise.
REQ-039 SHALL cover wrap: write 32'h12345678 at address 000045 (DEPTH 64) -> a read of address 000005 returns 12345678.
REQ-040 SHALL cover abort: write to address 000007 with CSbar raised at k = 50 -> no writeDone pulse; mem[7] unchanged; busy low the cycle after.
REQ-041 SHALL cover bad opcode: opcode 8'hAB then 56 more bits -> DO stays 0, no write, state DONE until CSbar rises.
REQ-042 SHALL cover reset: rst high at k = 40 of a read -> the next cycle has DO = 0, busy = 0; a new transaction then completes normally.

Source files
------------

// File: rtl/off_chip_spi_flash_pkg.sv
// ============================================================================
// Module  : off_chip_spi_flash_pkg
// Brief   : Shared opcodes, state encoding and sizing defaults for the
//           off-chip SPI flash initiator and responder.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package off_chip_spi_flash_pkg;

    localparam int          c_depth_default    = 64;
    localparam int          c_aw_default       = 6;
    localparam logic [7:0]  c_read_op_default  = 8'h03;
    localparam logic [7:0]  c_write_op_default = 8'h02;

    // Last bit-counter value of each transaction phase.
    localparam logic [5:0]  c_k_cmd_last  = 6'd7;
    localparam logic [5:0]  c_k_addr_last = 6'd31;
    localparam logic [5:0]  c_k_data_last = 6'd63;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CMD   = 3'd1,
        ST_ADDR  = 3'd2,
        ST_READ  = 3'd3,
        ST_WRITE = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

endpackage

`default_nettype wire

// File: rtl/off_chip_spi_flash_shift_reg.sv
// ============================================================================
// Module  : off_chip_spi_flash_shift_reg
// Brief   : Parallel-load, shift-left register with serial input.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module off_chip_spi_flash_shift_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    input  logic             si,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else if (load) begin
            r_q <= din;
        end else if (shift) begin
            r_q <= {r_q[WIDTH-2:0], si};
        end
    end

    assign q = r_q;

endmodule

`default_nettype wire

// File: rtl/off_chip_spi_flash_responder.sv
// ============================================================================
// Module  : off_chip_spi_flash_responder
// Brief   : SPI-style flash responder: 8-bit opcode, 24-bit address, 32-bit
//           read/write data word against an internal word memory.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module off_chip_spi_flash_responder
    import off_chip_spi_flash_pkg::*;
#(
    parameter int         DEPTH    = c_depth_default,
    parameter int         AW       = c_aw_default,
    parameter logic [7:0] READ_OP  = c_read_op_default,
    parameter logic [7:0] WRITE_OP = c_write_op_default
) (
    input  logic clk,
    input  logic rst,
    input  logic CSbar,
    input  logic DI,
    output logic DO,
    output logic busy,
    output logic writeDone
);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [5:0]    r_cnt;
    logic [7:0]    r_opcode;
    logic [AW-1:0] r_idx;
    logic [AW-1:0] w_rd_idx;
    logic [31:0]   r_mem [DEPTH];
    logic [31:0]   w_rd_word;
    logic [31:0]   w_sr_q;
    logic          w_load;
    logic          w_shift;
    logic          w_commit;
    logic          w_do_nxt;
    logic          r_do;
    logic          r_write_done;

    // The final address bit arrives on the same edge the read word is loaded.
    assign w_rd_idx  = {r_idx[AW-2:0], DI};
    assign w_rd_word = r_mem[w_rd_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_shift     = 1'b0;
        w_commit    = 1'b0;
        if (CSbar) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:  w_state_nxt = ST_CMD;
                ST_CMD:   if (r_cnt == c_k_cmd_last) w_state_nxt = ST_ADDR;
                ST_ADDR: begin
                    if (r_cnt == c_k_addr_last) begin
                        if (r_opcode == READ_OP) begin
                            w_state_nxt = ST_READ;
                            w_load      = 1'b1;
                        end else if (r_opcode == WRITE_OP) begin
                            w_state_nxt = ST_WRITE;
                        end else begin
                            w_state_nxt = ST_DONE;
                        end
                    end
                end
                ST_READ: begin
                    w_shift = 1'b1;
                    if (r_cnt == c_k_data_last) w_state_nxt = ST_DONE;
                end
                ST_WRITE: begin
                    w_shift = 1'b1;
                    if (r_cnt == c_k_data_last) begin
                        w_state_nxt = ST_DONE;
                        w_commit    = 1'b1;
                    end
                end
                ST_DONE:  w_state_nxt = ST_DONE;
                default:  w_state_nxt = ST_IDLE;
            endcase
        end
        // DO mirrors the MSB the shift register will hold after this edge.
        w_do_nxt = 1'b0;
        if (w_state_nxt == ST_READ) begin
            w_do_nxt = w_load ? w_rd_word[31] : (w_shift ? w_sr_q[30] : w_sr_q[31]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt        <= '0;
            r_opcode     <= '0;
            r_idx        <= '0;
            r_do         <= 1'b0;
            r_write_done <= 1'b0;
        end else begin
            r_do         <= w_do_nxt;
            r_write_done <= w_commit;
            if (w_state_nxt == ST_IDLE) begin
                r_cnt <= '0;
            end else if (r_cnt != c_k_data_last) begin
                r_cnt <= r_cnt + 6'd1;
            end
            if (!CSbar && (r_state == ST_IDLE || r_state == ST_CMD)) begin
                r_opcode <= {r_opcode[6:0], DI};
            end
            if (!CSbar && r_state == ST_ADDR) begin
                r_idx <= w_rd_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_commit && !rst) begin
            r_mem[r_idx] <= {w_sr_q[30:0], DI};
        end
    end

    off_chip_spi_flash_shift_reg #(
        .WIDTH (32)
    ) u_shift_reg (
        .clk   (clk),
        .rst   (rst),
        .load  (w_load),
        .shift (w_shift),
        .din   (w_rd_word),
        .si    (DI),
        .q     (w_sr_q)
    );

    assign DO        = r_do;
    assign busy      = (r_state != ST_IDLE);
    assign writeDone = r_write_done;

endmodule

`default_nettype wire

// File: tb/tb_off_chip_spi_flash_responder.sv
// ============================================================================
// Module  : tb_off_chip_spi_flash_responder
// Brief   : Self-checking bench for the SPI flash responder with a word-level
//           memory reference model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_off_chip_spi_flash_responder;

    localparam int         c_depth = 64;
    localparam logic [7:0] c_rd    = 8'h03;
    localparam logic [7:0] c_wr    = 8'h02;

    logic clk;
    logic rst;
    logic CSbar;
    logic DI;
    logic DO;
    logic busy;
    logic writeDone;

    int          vectors;
    int          miscompares;
    logic [31:0] model_mem [c_depth];

    off_chip_spi_flash_responder dut (
        .clk       (clk),
        .rst       (rst),
        .CSbar     (CSbar),
        .DI        (DI),
        .DO        (DO),
        .busy      (busy),
        .writeDone (writeDone)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic csb, input logic di, input logic r);
        CSbar = csb;
        DI    = di;
        rst   = r;
        @(posedge clk);
        #1;
    endtask

    // stop_kind: 0 = full transaction, 1 = CSbar raised at stop_k, 2 = rst at stop_k
    task automatic xact(input logic [7:0] op, input logic [23:0] addr, input logic [31:0] data,
                        input int stop_k, input int stop_kind, input int extra);
        logic [63:0] frame;
        logic [31:0] exp_rd;
        logic        exp_do;
        int          idx;
        bit          is_rd;
        bit          is_wr;
        frame  = {op, addr, data};
        idx    = int'(addr) % c_depth;
        is_rd  = (op == c_rd);
        is_wr  = (op == c_wr);
        exp_rd = model_mem[idx];
        for (int k = 0; k < 64; k++) begin
            if (k == stop_k) break;
            step(1'b0, frame[63-k], 1'b0);
            exp_do = (is_rd && k >= 31 && k <= 62) ? exp_rd[62-k] : 1'b0;
            check("do", {31'd0, DO}, {31'd0, exp_do});
            check("busy", {31'd0, busy}, 32'd1);
            check("writeDone", {31'd0, writeDone}, {31'd0, (is_wr && k == 63)});
        end
        if (stop_k >= 64) begin
            for (int e = 0; e < extra; e++) begin
                step(1'b0, 1'($urandom), 1'b0);
                check("done_do", {31'd0, DO}, 32'd0);
                check("done_busy", {31'd0, busy}, 32'd1);
                check("done_writeDone", {31'd0, writeDone}, 32'd0);
            end
        end
        if (stop_k < 64 && stop_kind == 2) begin
            step(1'b0, 1'($urandom), 1'b1);
        end else begin
            step(1'b1, 1'($urandom), 1'b0);
        end
        check("end_do", {31'd0, DO}, 32'd0);
        check("end_busy", {31'd0, busy}, 32'd0);
        check("end_writeDone", {31'd0, writeDone}, 32'd0);
        if (is_wr && stop_k >= 64) model_mem[idx] = data;
    endtask

    initial begin
        logic [7:0] op;
        int         sel;
        int         stop_k;
        int         stop_kind;
        vectors     = 0;
        miscompares = 0;
        rst   = 1'b1;
        CSbar = 1'b0;
        DI    = 1'b1;
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        check("reset_do", {31'd0, DO}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_writeDone", {31'd0, writeDone}, 32'd0);
        step(1'b1, 1'b0, 1'b0);
        check("idle_busy", {31'd0, busy}, 32'd0);

        for (int i = 0; i < c_depth; i++) begin
            xact(c_wr, 24'(i), $urandom, 64, 0, 0);
        end

        xact(c_wr, 24'h000005, 32'hDEADBEEF, 64, 0, 0);
        xact(c_rd, 24'h000005, $urandom, 64, 0, 0);
        xact(c_wr, 24'h000045, 32'h12345678, 64, 0, 0);
        xact(c_rd, 24'h000005, $urandom, 64, 0, 0);
        xact(c_wr, 24'h000007, 32'hA5A5F00F, 50, 1, 0);
        xact(c_rd, 24'h000007, $urandom, 64, 0, 0);
        xact(8'hAB, 24'($urandom), $urandom, 64, 0, 5);
        xact(c_rd, 24'h000005, $urandom, 40, 2, 0);
        xact(c_rd, 24'h000005, $urandom, 64, 0, 0);
        xact(c_wr, 24'h000009, 32'h0BADF00D, 64, 0, 3);
        xact(c_rd, 24'h000009, $urandom, 64, 0, 2);

        for (int i = 0; i < 60; i++) begin
            sel = int'($urandom_range(0, 3));
            if (sel <= 1)      op = c_rd;
            else if (sel == 2) op = c_wr;
            else               op = 8'($urandom);
            stop_k    = 64;
            stop_kind = 0;
            if ($urandom_range(0, 5) == 0) begin
                stop_k    = int'($urandom_range(0, 63));
                stop_kind = int'($urandom_range(1, 2));
            end
            xact(op, 24'($urandom), $urandom, stop_k, stop_kind, int'($urandom_range(0, 3)));
        end

        for (int i = 0; i < 8; i++) begin
            xact(c_rd, 24'($urandom), $urandom, 64, 0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
